satalnk_rmcont_wide: RTL and testbench



---
 rtl/satalnk_rmcont_wide_pkg.sv | 46 ++++
 rtl/satalnk_rmcont_wide_lane.sv | 85 ++++++++
 rtl/satalnk_rmcont_wide.sv | 122 ++++++++++++
 tb/tb_satalnk_rmcont_wide.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/satalnk_rmcont_wide_pkg.sv
// Shared SATA primitive constants and lane classification for satalnk_rmcont_wide.
// Each primitive is a 33-bit {primitive flag, 32-bit dword} value.
package satalnk_rmcont_wide_pkg;

  localparam logic [32:0] P_ALIGN   = {1'b1, 32'h7B4A_4ABC};
  localparam logic [32:0] P_CONT    = {1'b1, 32'h9999_AA7C};
  localparam logic [32:0] P_SYNC    = {1'b1, 32'hB5B5_957C};
  localparam logic [32:0] P_HOLD    = {1'b1, 32'hD5D5_AA7C};
  localparam logic [32:0] P_HOLDA   = {1'b1, 32'h9595_AA7C};
  localparam logic [32:0] P_R_RDY   = {1'b1, 32'h4A4A_957C};
  localparam logic [32:0] P_X_RDY   = {1'b1, 32'h5757_B57C};
  localparam logic [32:0] P_R_IP    = {1'b1, 32'h5555_B57C};
  localparam logic [32:0] P_R_OK    = {1'b1, 32'h3535_B57C};
  localparam logic [32:0] P_R_ERR   = {1'b1, 32'h5656_B57C};
  localparam logic [32:0] P_SOF     = {1'b1, 32'h3737_B57C};
  localparam logic [32:0] P_EOF     = {1'b1, 32'hD5D5_B57C};
  localparam logic [32:0] P_WTRM    = {1'b1, 32'h5858_B57C};
  localparam logic [32:0] P_DMAT    = {1'b1, 32'h3636_B57C};
  localparam logic [32:0] P_PMREQ_P = {1'b1, 32'h1717_B57C};
  localparam logic [32:0] P_PMREQ_S = {1'b1, 32'h7575_957C};
  localparam logic [32:0] P_PMACK   = {1'b1, 32'h9595_957C};
  localparam logic [32:0] P_PMNAK   = {1'b1, 32'hF5F5_957C};

  typedef enum logic [1:0] {
    CLS_CONT  = 2'd0,
    CLS_ALIGN = 2'd1,
    CLS_PRIM  = 2'd2,
    CLS_DATA  = 2'd3
  } lane_class_e;

  // Classify one received word; CONT and ALIGN need the primitive flag set.
  function automatic lane_class_e classify(input logic prim, input logic [31:0] data);
    lane_class_e cls;
    if ({prim, data} == P_CONT) begin
      cls = CLS_CONT;
    end else if ({prim, data} == P_ALIGN) begin
      cls = CLS_ALIGN;
    end else if (prim) begin
      cls = CLS_PRIM;
    end else begin
      cls = CLS_DATA;
    end
    return cls;
  endfunction

endpackage

// File: rtl/satalnk_rmcont_wide_lane.sv
// One combinational CONT-removal step for a single 32-bit lane.
// Optional feature macro: SATALNK_RMCONT_REPEAT_EN (CONT/junk lanes kept as primitive repeats).
module satalnk_rmcont_lane
  import satalnk_rmcont_wide_pkg::*;
#(
  parameter int OPT_DROP_ALIGN = 1
) (
  input  logic        i_active,
  input  logic [31:0] i_last,
  input  logic        i_last_vld,
  input  logic        i_prim,
  input  logic [31:0] i_data,
  output logic        o_active,
  output logic [31:0] o_last,
  output logic        o_last_vld,
  output logic        o_keep,
  output logic        o_prim,
  output logic [31:0] o_data,
  output logic        o_orphan,
  output logic        o_count
);

`ifdef SATALNK_RMCONT_REPEAT_EN
  localparam logic REPEAT_KEEP = 1'b1;
`else
  localparam logic REPEAT_KEEP = 1'b0;
`endif

  logic w_align_keep;
  assign w_align_keep = (OPT_DROP_ALIGN == 0) ? 1'b1 : 1'b0;

  // Next state and output word for this lane given the state left by older lanes.
  always_comb begin
    o_active   = i_active;
    o_last     = i_last;
    o_last_vld = i_last_vld;
    o_keep     = 1'b1;
    o_prim     = i_prim;
    o_data     = i_data;
    o_orphan   = 1'b0;
    o_count    = 1'b0;
    case (classify(i_prim, i_data))
      CLS_CONT: begin
        if (i_last_vld) begin
          o_active = 1'b1;
          o_keep   = REPEAT_KEEP;
          o_count  = ~REPEAT_KEEP;
          o_prim   = 1'b1;
          o_data   = i_last;
        end else begin
          // Nothing legal to repeat: report it and drop the word.
          o_keep   = 1'b0;
          o_count  = 1'b1;
          o_prim   = 1'b0;
          o_data   = 32'h0000_0000;
          o_orphan = 1'b1;
        end
      end
      CLS_ALIGN: begin
        // ALIGN is transparent to the run state; a dropped ALIGN is not counted.
        o_keep = w_align_keep;
      end
      CLS_PRIM: begin
        o_active   = 1'b0;
        o_last     = i_data;
        o_last_vld = 1'b1;
      end
      CLS_DATA: begin
        if (i_active) begin
          // Scrambled filler inside a CONT run stands for the repeated primitive.
          o_keep  = REPEAT_KEEP;
          o_count = ~REPEAT_KEEP;
          o_prim  = 1'b1;
          o_data  = i_last;
        end else begin
          o_last_vld = 1'b0;
        end
      end
      default: begin
        o_keep = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/satalnk_rmcont_wide.sv
// Multi-lane receive CONT removal: chains NLANES lane steps per beat and
// holds run state, registered outputs and the saturating dropped-word counter.
// Optional feature macro: SATALNK_RMCONT_REPEAT_EN (handled in the lane step).
module satalnk_rmcont_wide
  import satalnk_rmcont_wide_pkg::*;
#(
  parameter int NLANES         = 2,
  parameter int CW             = 16,
  parameter int OPT_DROP_ALIGN = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NLANES-1:0]    i_primitive,
  input  logic [32*NLANES-1:0] i_data,
  output logic                 o_valid,
  output logic [NLANES-1:0]    o_keep,
  output logic [NLANES-1:0]    o_primitive,
  output logic [32*NLANES-1:0] o_data,
  output logic                 o_err_orphan,
  output logic [CW-1:0]        o_dropped
);

  logic [NLANES:0]             w_active;
  logic [NLANES:0]             w_last_vld;
  logic [NLANES:0][31:0]       w_last;
  logic [NLANES-1:0]           w_keep;
  logic [NLANES-1:0]           w_prim;
  logic [NLANES-1:0]           w_orphan;
  logic [NLANES-1:0]           w_count;
  logic [NLANES-1:0][31:0]     w_data;
  logic [CW+2:0]               w_add;
  logic [CW+2:0]               w_sum;
  logic [CW-1:0]               w_dropped_next;

  logic                        r_active;
  logic [31:0]                 r_last;
  logic                        r_last_vld;
  logic                        r_valid;
  logic [NLANES-1:0]           r_keep;
  logic [NLANES-1:0]           r_prim;
  logic [32*NLANES-1:0]        r_data;
  logic                        r_orphan;
  logic [CW-1:0]               r_dropped;

  assign w_active[0]   = r_active;
  assign w_last[0]     = r_last;
  assign w_last_vld[0] = r_last_vld;

  // Lane 0 is the oldest word; each lane sees the state left by the lanes before it.
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    satalnk_rmcont_lane #(
      .OPT_DROP_ALIGN(OPT_DROP_ALIGN)
    ) u_lane (
      .i_active   (w_active[k]),
      .i_last     (w_last[k]),
      .i_last_vld (w_last_vld[k]),
      .i_prim     (i_primitive[k]),
      .i_data     (i_data[32*k +: 32]),
      .o_active   (w_active[k+1]),
      .o_last     (w_last[k+1]),
      .o_last_vld (w_last_vld[k+1]),
      .o_keep     (w_keep[k]),
      .o_prim     (w_prim[k]),
      .o_data     (w_data[k]),
      .o_orphan   (w_orphan[k]),
      .o_count    (w_count[k])
    );
  end

  // Add this beat's suppressed lanes with headroom, then clamp at all-ones.
  always_comb begin
    w_add = {(CW+3){1'b0}};
    for (int k = 0; k < NLANES; k++) begin
      w_add = w_add + {{(CW+2){1'b0}}, w_count[k]};
    end
    w_sum = {3'b000, r_dropped} + w_add;
    if (w_sum > {3'b000, {CW{1'b1}}}) begin
      w_dropped_next = {CW{1'b1}};
    end else begin
      w_dropped_next = w_sum[CW-1:0];
    end
  end

  // Run state, output registers and counter; idle beats leave state untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active   <= 1'b0;
      r_last     <= 32'h0000_0000;
      r_last_vld <= 1'b0;
      r_valid    <= 1'b0;
      r_keep     <= {NLANES{1'b0}};
      r_prim     <= {NLANES{1'b0}};
      r_data     <= {(32*NLANES){1'b0}};
      r_orphan   <= 1'b0;
      r_dropped  <= {CW{1'b0}};
    end else begin
      r_valid <= i_valid;
      r_prim  <= w_prim;
      r_data  <= w_data;
      if (i_valid) begin
        r_active   <= w_active[NLANES];
        r_last     <= w_last[NLANES];
        r_last_vld <= w_last_vld[NLANES];
        r_keep     <= w_keep;
        r_orphan   <= |w_orphan;
        r_dropped  <= w_dropped_next;
      end else begin
        r_keep   <= {NLANES{1'b0}};
        r_orphan <= 1'b0;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_keep       = r_keep;
  assign o_primitive  = r_prim;
  assign o_data       = r_data;
  assign o_err_orphan = r_orphan;
  assign o_dropped    = r_dropped;

endmodule

// File: tb/tb_satalnk_rmcont_wide.sv
// Self-checking bench for satalnk_rmcont_wide (NLANES=2): table of beats with a
// scoreboard queue, plus a hand-written saturation sequence on a CW=4 instance.
// Expectations follow SATALNK_RMCONT_REPEAT_EN when that macro is defined.
module tb_satalnk_rmcont_wide;

  localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] CONT  = 32'h9999_AA7C;
  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] RRDY  = 32'h4A4A_957C;

`ifdef SATALNK_RMCONT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    bit          rst;
    bit          vld;
    logic [1:0]  prim;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  keep;
    logic [1:0]  keep_rep;
    logic [1:0]  eprim;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  mask;
    logic        orph;
    logic [15:0] drop;
    logic [15:0] drop_rep;
  } vec_t;

  typedef struct {
    logic [1:0]  keep;
    logic [1:0]  eprim;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  mask;
    logic        orph;
    logic [15:0] drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [1:0]  prim = 2'b00;
  logic [63:0] data = 64'h0;
  logic        o_valid, o_orph, o2_valid, o2_orph;
  logic [1:0]  o_keep, o_prim, o2_keep, o2_prim;
  logic [63:0] o_data, o2_data;
  logic [15:0] o_dropped;
  logic [3:0]  o2_dropped;

  int checks = 0;
  int failures = 0;
  vec_t tbl[15];
  exp_t sb[$];

  always #5 clk = ~clk;

  satalnk_rmcont_wide #(.NLANES(2), .CW(16), .OPT_DROP_ALIGN(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_primitive(prim), .i_data(data),
    .o_valid(o_valid), .o_keep(o_keep), .o_primitive(o_prim), .o_data(o_data),
    .o_err_orphan(o_orph), .o_dropped(o_dropped));

  satalnk_rmcont_wide #(.NLANES(2), .CW(4), .OPT_DROP_ALIGN(1)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_primitive(prim), .i_data(data),
    .o_valid(o2_valid), .o_keep(o2_keep), .o_primitive(o2_prim), .o_data(o2_data),
    .o_err_orphan(o2_orph), .o_dropped(o2_dropped));

  function automatic vec_t mk(bit r, bit v, logic [1:0] p, logic [31:0] a, logic [31:0] b,
                              logic [1:0] k, logic [1:0] kr, logic [1:0] ep,
                              logic [31:0] ea, logic [31:0] eb, logic [1:0] m,
                              logic eo, logic [15:0] dr, logic [15:0] drr);
    vec_t x;
    x.rst = r; x.vld = v; x.prim = p; x.d0 = a; x.d1 = b;
    x.keep = k; x.keep_rep = kr; x.eprim = ep; x.e0 = ea; x.e1 = eb;
    x.mask = m; x.orph = eo; x.drop = dr; x.drop_rep = drr;
    return x;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; vld = 1'b0; prim = 2'b00; data = 64'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive(logic v, logic [1:0] p, logic [31:0] a, logic [31:0] b);
    vld = v; prim = p; data = {b, a};
    @(posedge clk); #1;
  endtask

  // Compare the DUT's current output beat against the oldest scoreboard entry.
  task automatic score(int idx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty vec %0d: output with no expected entry", idx);
      return;
    end
    e = sb.pop_front();
    check($sformatf("valid[%0d]", idx), {63'h0, o_valid}, {63'h0, vld});
    check($sformatf("keep[%0d]", idx), {62'h0, o_keep}, {62'h0, e.keep});
    check($sformatf("orphan[%0d]", idx), {63'h0, o_orph}, {63'h0, e.orph});
    check($sformatf("dropped[%0d]", idx), {48'h0, o_dropped}, {48'h0, e.drop});
    if (e.mask[0]) begin
      check($sformatf("prim0[%0d]", idx), {63'h0, o_prim[0]}, {63'h0, e.eprim[0]});
      check($sformatf("data0[%0d]", idx), {32'h0, o_data[31:0]}, {32'h0, e.e0});
    end
    if (e.mask[1]) begin
      check($sformatf("prim1[%0d]", idx), {63'h0, o_prim[1]}, {63'h0, e.eprim[1]});
      check($sformatf("data1[%0d]", idx), {32'h0, o_data[63:32]}, {32'h0, e.e1});
    end
  endtask

  initial begin
    exp_t e;
    // rst vld prim d0 d1 | keep keep_rep eprim e0 e1 mask orph drop drop_rep
    tbl[0]  = mk(1, 1, 2'b11, HOLD, CONT, 2'b01, 2'b11, 2'b11, HOLD, HOLD, 2'b11, 1'b0, 16'd1, 16'd0);
    tbl[1]  = mk(0, 1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 2'b11, 2'b11, HOLD, HOLD, 2'b11, 1'b0, 16'd3, 16'd0);
    tbl[2]  = mk(0, 1, 2'b01, ALIGN, 32'h1111_1111, 2'b00, 2'b10, 2'b11, 32'h0, HOLD, 2'b10, 1'b0, 16'd4, 16'd0);
    tbl[3]  = mk(0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 16'd4, 16'd0);
    tbl[4]  = mk(0, 1, 2'b00, 32'h2222_2222, 32'h3333_3333, 2'b00, 2'b11, 2'b11, HOLD, HOLD, 2'b11, 1'b0, 16'd6, 16'd0);
    tbl[5]  = mk(0, 1, 2'b01, RRDY, 32'h0000_0001, 2'b11, 2'b11, 2'b01, RRDY, 32'h1, 2'b11, 1'b0, 16'd6, 16'd0);
    tbl[6]  = mk(0, 1, 2'b01, CONT, 32'h4444_4444, 2'b10, 2'b10, 2'b00, 32'h0, 32'h4444_4444, 2'b11, 1'b1, 16'd7, 16'd1);
    tbl[7]  = mk(0, 1, 2'b00, 32'h5555_5555, 32'h6666_6666, 2'b11, 2'b11, 2'b00, 32'h5555_5555, 32'h6666_6666, 2'b11, 1'b0, 16'd7, 16'd1);
    tbl[8]  = mk(1, 1, 2'b01, CONT, 32'hDEAD_BEEF, 2'b10, 2'b10, 2'b00, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b1, 16'd1, 16'd1);
    tbl[9]  = mk(0, 1, 2'b11, HOLD, CONT, 2'b01, 2'b11, 2'b11, HOLD, HOLD, 2'b11, 1'b0, 16'd2, 16'd1);
    tbl[10] = mk(1, 1, 2'b00, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b11, 2'b11, 2'b00, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b11, 1'b0, 16'd0, 16'd0);
    tbl[11] = mk(0, 1, 2'b11, SYNC, CONT, 2'b01, 2'b11, 2'b11, SYNC, SYNC, 2'b11, 1'b0, 16'd1, 16'd0);
    tbl[12] = mk(0, 1, 2'b11, ALIGN, CONT, 2'b00, 2'b10, 2'b11, 32'h0, SYNC, 2'b10, 1'b0, 16'd2, 16'd0);
    tbl[13] = mk(0, 1, 2'b10, 32'h7777_7777, SYNC, 2'b10, 2'b11, 2'b11, SYNC, SYNC, 2'b11, 1'b0, 16'd3, 16'd0);
    tbl[14] = mk(0, 1, 2'b10, 32'h8888_8888, CONT, 2'b01, 2'b01, 2'b00, 32'h8888_8888, 32'h0, 2'b11, 1'b1, 16'd4, 16'd1);

    // Reset state of both instances.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'h0, o_valid}, 64'h0);
    check("rst_keep", {62'h0, o_keep}, 64'h0);
    check("rst_prim", {62'h0, o_prim}, 64'h0);
    check("rst_data", o_data, 64'h0);
    check("rst_orphan", {63'h0, o_orph}, 64'h0);
    check("rst_dropped", {48'h0, o_dropped}, 64'h0);
    check("rst_dropped_sat", {60'h0, o2_dropped}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) pulse_reset();
      e.keep  = REP ? tbl[i].keep_rep : tbl[i].keep;
      e.drop  = REP ? tbl[i].drop_rep : tbl[i].drop;
      e.eprim = tbl[i].eprim;
      e.e0    = tbl[i].e0;
      e.e1    = tbl[i].e1;
      e.mask  = tbl[i].mask;
      e.orph  = tbl[i].orph;
      sb.push_back(e);
      drive(tbl[i].vld, tbl[i].prim, tbl[i].d0, tbl[i].d1);
      score(i);
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL sb_leftover: %0d entries never compared", sb.size());
    end

    // Saturation on the CW=4 instance: orphan pairs add 2 per beat.
    pulse_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 2'b11, CONT, CONT);
    check("sat_preload", {60'h0, o2_dropped}, 64'd14);
    drive(1'b1, 2'b11, CONT, CONT);
    check("sat_clamp", {60'h0, o2_dropped}, 64'd15);
    drive(1'b1, 2'b11, CONT, CONT);
    check("sat_hold", {60'h0, o2_dropped}, 64'd15);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sat_idle", {60'h0, o2_dropped}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
